load_store_unit: RTL

// - Memory stage placed directly after the ALU. Takes the ALU's effective address (memaddroffset),
//   the instruction word and the rt value. Runs one load or store on the Avalon-style data bus.
// - Loads: extracts the byte, halfword or word from the returned bus word, extends it and returns
//   it for rt writeback. Stores: drives the correct byte lanes.
// - Holds busy for the whole access, so the pipeline stalls while the bus asserts waitrequest.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/load_store_unit_if.sv | 28 ++
 rtl/byte_lane_align.sv | 69 ++++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared opcodes, load/store FSM state type and opcode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'd32;
    localparam logic [5:0] OP_LH  = 6'd33;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_LBU = 6'd36;
    localparam logic [5:0] OP_LHU = 6'd37;
    localparam logic [5:0] OP_SB  = 6'd40;
    localparam logic [5:0] OP_SH  = 6'd41;
    localparam logic [5:0] OP_SW  = 6'd43;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    // True for the eight load/store opcodes this unit executes.
    function automatic logic op_is_valid(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) ||
               (op == OP_LHU) || (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Avalon-style data bus between the load/store unit and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );

endinterface
`default_nettype wire

// File: rtl/byte_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : byte_lane_align
// Purpose  : Combinational opcode decode, byte-lane enables, store data
//            replication and load extraction/extension.
// Revision : 1.0 - initial release
// ============================================================================
module byte_lane_align
    import mips_pkg::*;
(
    input  wire logic [5:0]  opcode,
    input  wire logic [1:0]  offset,
    input  wire logic [31:0] rt,
    input  wire logic [31:0] readdata,
    output logic      [3:0]  byteenable,
    output logic      [31:0] writedata,
    output logic      [31:0] load_data,
    output logic             valid_op,
    output logic             is_load,
    output logic             misaligned
);

    access_size_t w_size;
    logic         w_signed;
    logic [31:0]  w_lane;

    // Decode size/signedness and derive lanes, store data and load result.
    always_comb begin
        w_size   = SZ_WORD;
        w_signed = 1'b0;
        case (opcode)
            OP_LB:  begin w_size = SZ_BYTE; w_signed = 1'b1; end
            OP_LBU: w_size = SZ_BYTE;
            OP_SB:  w_size = SZ_BYTE;
            OP_LH:  begin w_size = SZ_HALF; w_signed = 1'b1; end
            OP_LHU: w_size = SZ_HALF;
            OP_SH:  w_size = SZ_HALF;
            default: w_size = SZ_WORD;
        endcase

        valid_op   = op_is_valid(opcode);
        is_load    = ~opcode[3];
        misaligned = ((w_size == SZ_HALF) && offset[0]) ||
                     ((w_size == SZ_WORD) && (offset != 2'b00));

        // Lanes are little-endian; the lane shift is 8 * offset.
        w_lane = readdata >> {offset, 3'b000};

        case (w_size)
            SZ_BYTE: begin
                byteenable = 4'b0001 << offset;
                writedata  = {4{rt[7:0]}};
                load_data  = {{24{w_signed & w_lane[7]}}, w_lane[7:0]};
            end
            SZ_HALF: begin
                byteenable = 4'b0011 << offset;
                writedata  = {2{rt[15:0]}};
                load_data  = {{16{w_signed & w_lane[15]}}, w_lane[15:0]};
            end
            default: begin
                byteenable = 4'b1111;
                writedata  = rt;
                load_data  = w_lane;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory stage: runs one load or store per start on the data bus,
//            with misalignment detection and a waitrequest timeout.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import mips_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        start,
    input  wire logic [31:0] instructionword,
    input  wire logic [31:0] memaddroffset,
    input  wire logic [31:0] store_data,
    load_store_unit_if.master bus,
    output logic      [31:0] load_data,
    output logic             done,
    output logic             busy,
    output logic             addr_err,
    output logic             bus_err
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    lsu_state_t       r_state;
    logic [5:0]       r_op;
    logic [1:0]       r_k;
    logic [CNT_W-1:0] r_wait;

    logic [5:0]  w_op;
    logic [1:0]  w_k;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [31:0] w_ld;
    logic        w_valid_op;
    logic        w_is_load;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_unused_bits;

    // In IDLE the aligner decodes the incoming request; afterwards the latched one.
    assign w_op          = (r_state == IDLE) ? instructionword[31:26] : r_op;
    assign w_k           = (r_state == IDLE) ? memaddroffset[1:0]     : r_k;
    assign w_timeout     = (MAX_WAIT != 0) && (r_wait == CNT_W'(MAX_WAIT - 1));
    assign w_unused_bits = ^instructionword[25:0];

    byte_lane_align u_align (
        .opcode     (w_op),
        .offset     (w_k),
        .rt         (store_data),
        .readdata   (bus.readdata),
        .byteenable (w_be),
        .writedata  (w_wd),
        .load_data  (w_ld),
        .valid_op   (w_valid_op),
        .is_load    (w_is_load),
        .misaligned (w_misaligned)
    );

    // Access FSM with registered bus strobes, status flags and load result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_op           <= 6'd0;
            r_k            <= 2'd0;
            r_wait         <= '0;
            bus.address    <= 32'd0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.byteenable <= 4'd0;
            bus.writedata  <= 32'd0;
            load_data      <= 32'd0;
            done           <= 1'b0;
            busy           <= 1'b0;
            addr_err       <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy        <= 1'b1;
                        addr_err    <= 1'b0;
                        bus_err     <= 1'b0;
                        r_op        <= w_op;
                        r_k         <= w_k;
                        r_wait      <= '0;
                        bus.address <= {memaddroffset[31:2], 2'b00};
                        if (!w_valid_op) begin
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else if (w_misaligned) begin
                            addr_err <= 1'b1;
                            done     <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            bus.byteenable <= w_be;
                            bus.writedata  <= w_wd;
                            bus.read       <= w_is_load;
                            bus.write      <= ~w_is_load;
                            r_state        <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!bus.waitrequest) begin
                        if (bus.read) begin
                            load_data <= w_ld;
                        end
                        bus.read  <= 1'b0;
                        bus.write <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end else if (w_timeout) begin
                        bus.read  <= 1'b0;
                        bus.write <= 1'b0;
                        bus_err   <= 1'b1;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
